// File: rtl/carregador_matriz_4x4.sv
// Packs a stream of signed elements into a DIM x DIM matrix image for the combinational determinant unit.
// Latency: the element is written one cycle after acceptance; out_valido rises the cycle after the last accept.
// Backpressure: in_pronto drops while a full matrix is held until out_pronto; optional CARREGADOR_COLUNA_EN selects column-major loading.
module carregador_matriz_4x4 #(
    parameter int DATA_W = 8,
    parameter int DIM    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       limpar,
    input  logic signed [DATA_W-1:0]   in_dado,
    input  logic                       in_valido,
    input  logic                       in_ultimo,
    output logic                       in_pronto,
    output logic [DIM*DIM*DATA_W-1:0]  matriz_4x4,
    output logic                       out_valido,
    input  logic                       out_pronto,
    output logic [$clog2(DIM*DIM):0]   contagem,
    output logic                       erro_quadro
);

    localparam int NE = DIM * DIM;
    localparam int CW = $clog2(NE) + 1;
    localparam logic [CW-1:0] IDX_ULTIMO = CW'(NE - 1);
    localparam logic [CW-1:0] CONT_CHEIA = CW'(NE);

    typedef enum logic {
        RECEBENDO = 1'b0,
        CHEIA     = 1'b1
    } estado_t;

    estado_t         estado, estado_prox;
    logic [CW-1:0]   contagem_prox;
    logic            erro_prox;
    logic            grava;
    logic            aceita;
    logic            quadro_ok;
    logic [31:0]     n;
    logic [31:0]     destino;

    // Handshake outputs: no bypass, so in_pronto stays low through the handoff cycle.
    assign in_pronto  = (estado == RECEBENDO) && !rst && !limpar;
    assign out_valido = (estado == CHEIA);
    assign aceita     = in_valido && in_pronto;

    // Destination slot of the element currently being offered.
    always_comb begin
        n       = 32'(contagem);
        destino = '0;
`ifdef CARREGADOR_COLUNA_EN
        destino = (n % DIM) * DIM + n / DIM;
`else
        destino = n;
`endif
    end

    // Next-state logic: framing checks, counting and handoff.
    always_comb begin
        estado_prox   = estado;
        contagem_prox = contagem;
        erro_prox     = 1'b0;
        grava         = 1'b0;
        quadro_ok     = (in_ultimo == (contagem == IDX_ULTIMO));
        if (limpar) begin
            estado_prox   = RECEBENDO;
            contagem_prox = '0;
        end else begin
            case (estado)
                RECEBENDO: begin
                    if (aceita) begin
                        if (quadro_ok) begin
                            grava = 1'b1;
                            if (in_ultimo) begin
                                estado_prox   = CHEIA;
                                contagem_prox = CONT_CHEIA;
                            end else begin
                                contagem_prox = contagem + 1'b1;
                            end
                        end else begin
                            // Misframed element is dropped and the matrix restarts.
                            erro_prox     = 1'b1;
                            contagem_prox = '0;
                        end
                    end
                end
                CHEIA: begin
                    if (out_pronto) begin
                        estado_prox   = RECEBENDO;
                        contagem_prox = '0;
                    end
                end
                default: begin
                    estado_prox   = RECEBENDO;
                    contagem_prox = '0;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= RECEBENDO;
            contagem    <= '0;
            erro_quadro <= 1'b0;
        end else begin
            estado      <= estado_prox;
            contagem    <= contagem_prox;
            erro_quadro <= erro_prox;
        end
    end

    // Matrix image: only the addressed byte changes, older bytes persist across matrices.
    always_ff @(posedge clk) begin
        if (rst) begin
            matriz_4x4 <= '0;
        end else if (grava) begin
            matriz_4x4[destino*DATA_W +: DATA_W] <= in_dado;
        end
    end

endmodule
